// File: rtl/fetch_issue_sequencer_if.sv
// Fetch/issue sequencer bus: instruction memory, control unit and datapath signals.
// Optional INSTR_COUNT_EN adds the retired-instruction counter output.
interface fetch_issue_sequencer_if #(
    parameter int unsigned PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_rdata;
    logic [15:0]     instr;
    logic [3:0]      opcode;
    logic            mode;
    logic            cu_enable;
    logic [1:0]      src_pc;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] ret_addr;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus2;
    logic            ex_en;
    logic            mem_en;
    logic            wb_en;
    logic            dmem_done;
    logic            instr_retired;
`ifdef INSTR_COUNT_EN
    logic [31:0]     retired_count;
`endif

    modport master (
        input  imem_valid, imem_rdata, src_pc, branch_target, jump_target, ret_addr, dmem_done,
        output imem_req, imem_addr, instr, opcode, mode, cu_enable, pc, pc_plus2,
               ex_en, mem_en, wb_en, instr_retired
`ifdef INSTR_COUNT_EN
        , output retired_count
`endif
    );

    modport slave (
        output imem_valid, imem_rdata, src_pc, branch_target, jump_target, ret_addr, dmem_done,
        input  imem_req, imem_addr, instr, opcode, mode, cu_enable, pc, pc_plus2,
               ex_en, mem_en, wb_en, instr_retired
`ifdef INSTR_COUNT_EN
        , input retired_count
`endif
    );
endinterface

// File: rtl/fetch_issue_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB instruction sequencer feeding the control unit.
// Define INSTR_COUNT_EN to add a 32-bit retired-instruction counter.
module fetch_issue_sequencer #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic                    clk,
    input logic                    reset,
    fetch_issue_sequencer_if.master bus
);
    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_LAST_ALU = 4'h4;
    localparam logic [OP_W-1:0] OP_LW       = 4'h5;
    localparam logic [OP_W-1:0] OP_LB       = 4'h6;
    localparam logic [OP_W-1:0] OP_SW       = 4'h7;
    localparam logic [OP_W-1:0] OP_LAST_BR  = 4'hB;
    localparam logic [OP_W-1:0] OP_JMP      = 4'hC;
    localparam logic [OP_W-1:0] OP_CALL     = 4'hD;
    localparam logic [OP_W-1:0] OP_RET      = 4'hE;
    localparam logic [OP_W-1:0] OP_SV       = 4'hF;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            id2_q, id2_d;
    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            imem_req_q, cu_enable_q, ex_en_q, mem_en_q, wb_en_q, retired_q;
    logic            retire;
    logic [OP_W-1:0] op;
    logic [PC_W-1:0] pc_plus2;
    logic [PC_W-1:0] pc_sel;

    assign op       = instr_q[15:12];
    assign pc_plus2 = pc_q + PC_W'(2);

    // Next-PC select; only consulted in the retire cycle.
    always_comb begin
        pc_sel = pc_plus2;
        unique case (bus.src_pc)
            2'b00: pc_sel = pc_plus2;
            2'b01: pc_sel = bus.branch_target;
            2'b10: pc_sel = bus.jump_target;
            2'b11: pc_sel = bus.ret_addr;
            default: pc_sel = pc_plus2;
        endcase
    end

    // Next-state; JMP/RET spend a second ID cycle (id2) waiting for the control unit.
    always_comb begin
        state_d = state_q;
        id2_d   = 1'b0;
        instr_d = instr_q;
        pc_d    = pc_q;
        retire  = 1'b0;
        unique case (state_q)
            S_IF: begin
                if (bus.imem_valid) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (op == OP_JMP || op == OP_RET) begin
                    if (id2_q) retire = 1'b1;
                    else       id2_d  = 1'b1;
                end else if (op == OP_CALL) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (op <= OP_LAST_ALU)                                  state_d = S_WB;
                else if (op == OP_LW || op == OP_LB || op == OP_SW || op == OP_SV) state_d = S_MEM;
                else                                                    retire  = 1'b1;
            end
            S_MEM: begin
                if (bus.dmem_done) begin
                    if (op == OP_LW || op == OP_LB) state_d = S_WB;
                    else                            retire  = 1'b1;
                end
            end
            S_WB:    retire  = 1'b1;
            default: state_d = S_IF;
        endcase
        if (retire) begin
            state_d = S_IF;
            pc_d    = {pc_sel[PC_W-1:1], 1'b0};
        end
    end

    // State and registered stage strobes decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IF;
            id2_q       <= 1'b0;
            instr_q     <= '0;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b1;
            cu_enable_q <= 1'b0;
            ex_en_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            wb_en_q     <= 1'b0;
            retired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            id2_q       <= id2_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            imem_req_q  <= (state_d == S_IF);
            cu_enable_q <= (state_d == S_ID) && !id2_d;
            ex_en_q     <= (state_d == S_EX);
            mem_en_q    <= (state_d == S_MEM);
            wb_en_q     <= (state_d == S_WB);
            retired_q   <= retire;
        end
    end

    // instr_retired is high in the first cycle the updated PC is visible.
    assign bus.imem_req      = imem_req_q;
    assign bus.imem_addr     = pc_q;
    assign bus.instr         = instr_q;
    assign bus.opcode        = instr_q[15:12];
    assign bus.mode          = instr_q[11];
    assign bus.cu_enable     = cu_enable_q;
    assign bus.pc            = pc_q;
    assign bus.pc_plus2      = pc_plus2;
    assign bus.ex_en         = ex_en_q;
    assign bus.mem_en        = mem_en_q;
    assign bus.wb_en         = wb_en_q;
    assign bus.instr_retired = retired_q;

`ifdef INSTR_COUNT_EN
    logic [31:0] retired_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       retired_count_q <= '0;
        else if (retire) retired_count_q <= retired_count_q + 32'd1;
    end

    assign bus.retired_count = retired_count_q;
`endif
endmodule

// File: tb/tb_fetch_issue_sequencer.sv
// Directed bench for fetch_issue_sequencer with a per-instruction stage model.
// Build with INSTR_COUNT_EN defined to also check retired_count.
module tb_fetch_issue_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_issue_sequencer_if #(.PC_W(16)) bus ();

    fetch_issue_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model state: architectural PC/instr, retire pending, retire count.
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_instr = 16'h0000;
    logic        ret_pend = 1'b0;
    int          m_cnt = 0;

    // Per-cycle expectations consumed by the compare process.
    logic        chk_en = 1'b0;
    logic        e_req, e_cu, e_ex, e_mem, e_wb, e_ret;
    logic [15:0] e_pc, e_instr;
    int          e_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req",  32'(bus.imem_req),      32'(e_req));
            chk("imem_addr", 32'(bus.imem_addr),     32'(e_pc));
            chk("cu_enable", 32'(bus.cu_enable),     32'(e_cu));
            chk("ex_en",     32'(bus.ex_en),         32'(e_ex));
            chk("mem_en",    32'(bus.mem_en),        32'(e_mem));
            chk("wb_en",     32'(bus.wb_en),         32'(e_wb));
            chk("retired",   32'(bus.instr_retired), 32'(e_ret));
            chk("pc",        32'(bus.pc),            32'(e_pc));
            chk("pc_plus2",  32'(bus.pc_plus2),      32'(16'(e_pc + 16'd2)));
            chk("instr",     32'(bus.instr),         32'(e_instr));
            chk("opcode",    32'(bus.opcode),        32'(e_instr[15:12]));
            chk("mode",      32'(bus.mode),          32'(e_instr[11]));
`ifdef INSTR_COUNT_EN
            chk("retired_count", bus.retired_count, 32'(e_cnt));
`endif
        end
    end

    // Stage codes: 0 IF, 1 ID, 2 second ID cycle, 3 EX, 4 MEM, 5 WB.
    task automatic run(input logic [15:0] ins, input logic [1:0] src,
                       input logic [15:0] bt, input logic [15:0] jt, input logic [15:0] ra,
                       input int dly, input int ifd);
        int st[$];
        int mem_n;
        logic [3:0]  op;
        logic [15:0] npc;
        op = ins[15:12];
        for (int i = 0; i <= ifd; i++) st.push_back(0);
        st.push_back(1);
        if (op <= 4'h4) begin
            st.push_back(3); st.push_back(5);
        end else if (op == 4'h5 || op == 4'h6) begin
            st.push_back(3);
            for (int i = 0; i <= dly; i++) st.push_back(4);
            st.push_back(5);
        end else if (op == 4'h7 || op == 4'hF) begin
            st.push_back(3);
            for (int i = 0; i <= dly; i++) st.push_back(4);
        end else if (op <= 4'hB) begin
            st.push_back(3);
        end else if (op == 4'hD) begin
            st.push_back(5);
        end else begin
            st.push_back(2);
        end
        case (src)
            2'b00:   npc = m_pc + 16'd2;
            2'b01:   npc = bt;
            2'b10:   npc = jt;
            default: npc = ra;
        endcase
        npc[0] = 1'b0;
        mem_n = 0;
        foreach (st[k]) begin
            int s;
            s = st[k];
            bus.imem_valid    = (s != 0) || (k == ifd);
            bus.imem_rdata    = (s == 0) ? ins : 16'($urandom);
            if (s == 4) begin
                bus.dmem_done = (mem_n == dly);
                mem_n++;
            end else begin
                bus.dmem_done = 1'b1;
            end
            bus.src_pc        = (k == st.size() - 1) ? src : ~src;
            bus.branch_target = bt;
            bus.jump_target   = jt;
            bus.ret_addr      = ra;
            e_req   = (s == 0);
            e_cu    = (s == 1);
            e_ex    = (s == 3);
            e_mem   = (s == 4);
            e_wb    = (s == 5);
            e_ret   = ret_pend && (k == 0);
            e_pc    = m_pc;
            e_instr = (s == 0) ? m_instr : ins;
            e_cnt   = m_cnt;
            @(posedge clk); #1;
        end
        m_pc     = npc;
        m_instr  = ins;
        ret_pend = 1'b1;
        m_cnt++;
    endtask

    initial begin
        bus.imem_valid = 1'b0; bus.imem_rdata = '0; bus.dmem_done = 1'b0; bus.src_pc = '0;
        bus.branch_target = '0; bus.jump_target = '0; bus.ret_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req",  32'(bus.imem_req),  32'd1);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'h0000);
        chk("rst_cu_enable", 32'(bus.cu_enable), 32'd0);
        chk("rst_ex_en",     32'(bus.ex_en),     32'd0);
        chk("rst_instr",     32'(bus.instr),     32'h0000);
        chk("rst_retired",   32'(bus.instr_retired), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        run(16'h1000, 2'b00, 16'h0, 16'h0, 16'h0, 0, 0);         // ADD
        chk("add_pc_lit", 32'(bus.pc), 32'h0002);
        run(16'h2345, 2'b00, 16'h0, 16'h0, 16'h0, 0, 0);         // ALU
        run(16'h5123, 2'b00, 16'h0, 16'h0, 16'h0, 3, 0);         // LW, dmem late
        chk("lw_pc_lit", 32'(bus.pc), 32'h0006);
        run(16'h7001, 2'b00, 16'h0, 16'h0, 16'h0, 0, 0);         // SW
        run(16'hA000, 2'b01, 16'h0040, 16'h0, 16'h0, 0, 0);      // BEQ taken
        chk("beq_taken_lit", 32'(bus.pc), 32'h0040);
        run(16'hA000, 2'b00, 16'h0080, 16'h0, 16'h0, 0, 0);      // BEQ not taken
        chk("beq_fall_lit", 32'(bus.pc), 32'h0042);
        run(16'hC000, 2'b10, 16'h0, 16'h0010, 16'h0, 0, 0);      // JMP
        chk("call_link_lit", 32'(bus.pc_plus2), 32'h0012);
        run(16'hD000, 2'b10, 16'h0, 16'h0100, 16'h0, 0, 0);      // CALL
        chk("call_pc_lit", 32'(bus.pc), 32'h0100);
        run(16'hE000, 2'b11, 16'h0, 16'h0, 16'h0012, 0, 0);      // RET
        chk("ret_pc_lit", 32'(bus.pc), 32'h0012);
        run(16'h6ABC, 2'b00, 16'h0, 16'h0, 16'h0, 1, 2);         // LB, slow fetch
`ifdef INSTR_COUNT_EN
        chk("count10_lit", bus.retired_count, 32'd10);
`endif
        run(16'hF000, 2'b00, 16'h0, 16'h0, 16'h0, 2, 0);         // SV
        run(16'hC000, 2'b10, 16'h0, 16'hFFFE, 16'h0, 0, 0);      // JMP to top
        run(16'h0800, 2'b00, 16'h0, 16'h0, 16'h0, 0, 0);         // ALU, mode=1, wraps
        chk("wrap_pc_lit", 32'(bus.pc), 32'h0000);
        run(16'h9000, 2'b01, 16'h0123, 16'h0, 16'h0, 0, 0);      // odd branch target
        chk("odd_target_lit", 32'(bus.pc), 32'h0122);

        // Reset while an LW waits in MEM.
        chk_en = 1'b0;
        bus.imem_valid = 1'b1; bus.imem_rdata = 16'h5000; bus.dmem_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mem_hold_lit", 32'(bus.mem_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mem_en",   32'(bus.mem_en),   32'd0);
        chk("rst_mid_pc",   32'(bus.pc),       32'h0000);
        chk("rst_mid_req",  32'(bus.imem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        m_pc = 16'h0000; m_instr = 16'h0000; ret_pend = 1'b0; m_cnt = 0;
        chk_en = 1'b1;
        run(16'h3000, 2'b00, 16'h0, 16'h0, 16'h0, 0, 0);
        chk("post_rst_pc_lit", 32'(bus.pc), 32'h0002);
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
